// File: rtl/ah_div_share_arb_if.sv
// ah_div_share_arb_if: requester-side and divider-side buses of the shared divider arbiter
interface ah_div_share_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 6
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_dividend;
    logic [NUM_REQ*WIDTH-1:0] req_divisor;
    logic [NUM_REQ-1:0]       gnt;
    logic                     div_start;
    logic [WIDTH-1:0]         div_dividend;
    logic [WIDTH-1:0]         div_divisor;
    logic                     div_data_valid;
    logic [WIDTH-1:0]         div_quotient;
    logic                     div_div_by_zero;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]         rsp_quotient;
    logic                     rsp_div_by_zero;
    modport slave (
        input  req, req_dividend, req_divisor, div_data_valid, div_quotient, div_div_by_zero,
        output gnt, div_start, div_dividend, div_divisor, rsp_valid, rsp_quotient, rsp_div_by_zero
    );
    modport master (
        output req, req_dividend, req_divisor, div_data_valid, div_quotient, div_div_by_zero,
        input  gnt, div_start, div_dividend, div_divisor, rsp_valid, rsp_quotient, rsp_div_by_zero
    );
endinterface

// File: rtl/ah_div_share_arb.sv
// ah_div_share_arb: round-robin sharing of one fixed-latency divider with ID tag tracking
module ah_div_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 6,
    parameter int LATENCY = 8,
    parameter int IDW     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    ah_div_share_arb_if.slave  bus,
    output logic               busy,
    output logic               tag_err
);
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   gnt_id;
    logic [IDW-1:0]   idx;
    logic [IDW-1:0]   issue_id;
    logic             found;
    logic [WIDTH-1:0] dvd [NUM_REQ];
    logic [WIDTH-1:0] dvs [NUM_REQ];
    logic [LATENCY-1:0] tag_v;
    logic [IDW-1:0]   tag_id [LATENCY];
    logic             tail_v;
    logic [IDW-1:0]   tail_id;

    genvar g;
    for (g = 0; g < NUM_REQ; g++) begin : g_lane
        assign dvd[g] = bus.req_dividend[g*WIDTH +: WIDTH];
        assign dvs[g] = bus.req_divisor[g*WIDTH +: WIDTH];
    end

    assign tail_v  = tag_v[LATENCY-1];
    assign tail_id = tag_id[LATENCY-1];
    assign busy    = (|tag_v) | bus.div_start;

    // first requester at or above the pointer, wrapping, wins the grant
    always_comb begin
        bus.gnt = '0;
        gnt_id  = '0;
        idx     = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDW'((32'(ptr) + 32'(k)) % NUM_REQ);
            if (!found && bus.req[idx]) begin
                found        = 1'b1;
                bus.gnt[idx] = 1'b1;
                gnt_id       = idx;
            end
        end
    end

    // advance the pointer past the winner and register its operands into the divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr              <= '0;
            issue_id         <= '0;
            bus.div_start    <= 1'b0;
            bus.div_dividend <= '0;
            bus.div_divisor  <= '0;
        end else begin
            bus.div_start <= found;
            if (found) begin
                ptr              <= (gnt_id == IDW'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
                issue_id         <= gnt_id;
                bus.div_dividend <= dvd[gnt_id];
                bus.div_divisor  <= dvs[gnt_id];
            end
        end
    end

    // tag shift register runs in lockstep with the divider pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            for (int i = 0; i < LATENCY; i++) tag_id[i] <= '0;
        end else begin
            tag_v[0]  <= bus.div_start;
            tag_id[0] <= issue_id;
            for (int i = 1; i < LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    // route an aligned result to its originator; any valid/tag disagreement is latched as an error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid       <= '0;
            bus.rsp_quotient    <= '0;
            bus.rsp_div_by_zero <= 1'b0;
            tag_err             <= 1'b0;
        end else begin
            bus.rsp_valid <= (bus.div_data_valid && tail_v) ? NUM_REQ'(1) << tail_id : '0;
            tag_err       <= tag_err | (bus.div_data_valid ^ tail_v);
            if (bus.div_data_valid && tail_v) begin
                bus.rsp_quotient    <= bus.div_quotient;
                bus.rsp_div_by_zero <= bus.div_div_by_zero;
            end
        end
    end
endmodule

// File: tb/tb_ah_div_share_arb.sv
// tb_ah_div_share_arb: directed table-driven bench with a fixed-latency divider model
module tb_ah_div_share_arb;
    localparam int LAT = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, tag_err;
    logic early = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    ah_div_share_arb_if #(.NUM_REQ(4), .WIDTH(6)) bus ();

    ah_div_share_arb #(.NUM_REQ(4), .WIDTH(6), .LATENCY(LAT), .IDW(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    logic       mv [LAT];
    logic [5:0] mq [LAT];
    logic       mz [LAT];

    // divider model: result appears LAT cycles after div_start is sampled
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                mv[i] <= 1'b0;
                mq[i] <= '0;
                mz[i] <= 1'b0;
            end
        end else begin
            mv[0] <= bus.div_start;
            mz[0] <= (bus.div_divisor == 6'd0);
            mq[0] <= (bus.div_divisor == 6'd0) ? 6'h3F :
                     6'($signed(bus.div_dividend) / $signed(bus.div_divisor));
            for (int i = 1; i < LAT; i++) begin
                mv[i] <= mv[i-1];
                mq[i] <= mq[i-1];
                mz[i] <= mz[i-1];
            end
        end
    end

    assign bus.div_data_valid  = early ? mv[LAT-2] : mv[LAT-1];
    assign bus.div_quotient    = early ? mq[LAT-2] : mq[LAT-1];
    assign bus.div_div_by_zero = early ? mz[LAT-2] : mz[LAT-1];

    typedef struct {
        logic [3:0] req;
        int         win;
        logic [5:0] dvd;
        logic [5:0] dvs;
        logic [5:0] q;
        logic       dz;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [3:0] r);
        @(negedge clk);
        bus.req = r;
        #1;
    endtask

    task automatic set_ops(input int win, input logic [5:0] dv, input logic [5:0] ds);
        logic [5:0] a [4];
        logic [5:0] b [4];
        for (int i = 0; i < 4; i++) begin
            a[i] = (i == win) ? dv : 6'(10 + i);
            b[i] = (i == win) ? ds : 6'd1;
        end
        bus.req_dividend = {a[3], a[2], a[1], a[0]};
        bus.req_divisor  = {b[3], b[2], b[1], b[0]};
    endtask

    task automatic chk_reset_vals();
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_div_start", 32'(bus.div_start), 0);
        chk("rst_div_dividend", 32'(bus.div_dividend), 0);
        chk("rst_div_divisor", 32'(bus.div_divisor), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_quotient", 32'(bus.rsp_quotient), 0);
        chk("rst_rsp_dbz", 32'(bus.rsp_div_by_zero), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tag_err", 32'(tag_err), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'b0100, 2, 6'h14, 6'h03, 6'h06, 1'b0};
        tbl[1] = '{4'b0011, 0, 6'h2C, 6'h03, 6'h3A, 1'b0};
        tbl[2] = '{4'b1001, 3, 6'h1F, 6'h3C, 6'h39, 1'b0};
        tbl[3] = '{4'b0001, 0, 6'h07, 6'h00, 6'h3F, 1'b1};
        tbl[4] = '{4'b1110, 1, 6'h20, 6'h3F, 6'h20, 1'b0};
        tbl[5] = '{4'b0010, 1, 6'h31, 6'h05, 6'h3D, 1'b0};
        bus.req = '0;
        bus.req_dividend = '0;
        bus.req_divisor = '0;

        step(4'b0000);
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            set_ops(tbl[v].win, tbl[v].dvd, tbl[v].dvs);
            step(tbl[v].req);
            chk($sformatf("v%0d_gnt", v), 32'(bus.gnt), 32'(4'(1) << tbl[v].win));
            step(4'b0000);
            chk($sformatf("v%0d_div_start", v), 32'(bus.div_start), 1);
            chk($sformatf("v%0d_div_dividend", v), 32'(bus.div_dividend), 32'(tbl[v].dvd));
            chk($sformatf("v%0d_div_divisor", v), 32'(bus.div_divisor), 32'(tbl[v].dvs));
            for (int c = 2; c < 10; c++) begin
                step(4'b0000);
                chk($sformatf("v%0d_no_rsp_c%0d", v, c), 32'(bus.rsp_valid), 0);
            end
            step(4'b0000);
            chk($sformatf("v%0d_rsp_valid", v), 32'(bus.rsp_valid), 32'(4'(1) << tbl[v].win));
            chk($sformatf("v%0d_rsp_quotient", v), 32'(bus.rsp_quotient), 32'(tbl[v].q));
            chk($sformatf("v%0d_rsp_dbz", v), 32'(bus.rsp_div_by_zero), 32'(tbl[v].dz));
            step(4'b0000);
            chk($sformatf("v%0d_rsp_drop", v), 32'(bus.rsp_valid), 0);
            chk($sformatf("v%0d_idle_busy", v), 32'(busy), 0);
        end
        chk("tag_err_after_table", 32'(tag_err), 0);

        set_ops(1, 6'd9, 6'd3);
        step(4'b0010);
        chk("fair_gnt1", 32'(bus.gnt), 32'(4'b0010));
        step(4'b1001);
        chk("fair_gnt3", 32'(bus.gnt), 32'(4'b1000));
        step(4'b1001);
        chk("fair_gnt0", 32'(bus.gnt), 32'(4'b0001));
        repeat (14) step(4'b0000);
        chk("fair_busy_idle", 32'(busy), 0);
        chk("fair_tag_err", 32'(tag_err), 0);

        set_ops(1, 6'd12, 6'd4);
        step(4'b0110);
        chk("mid_gnt1", 32'(bus.gnt), 32'(4'b0010));
        step(4'b0110);
        chk("mid_gnt2", 32'(bus.gnt), 32'(4'b0100));
        repeat (4) step(4'b0000);
        chk("mid_busy_before_rst", 32'(busy), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        step(4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step(4'b0000);
            chk($sformatf("mid_no_rsp_c%0d", c), 32'(bus.rsp_valid), 0);
        end
        chk("mid_busy_after", 32'(busy), 0);

        bus.req_dividend = {6'd24, 6'd18, 6'd12, 6'd6};
        bus.req_divisor  = {6'd2, 6'd2, 6'd2, 6'd2};
        for (int c = 0; c < 21; c++) begin
            step(c < 8 ? 4'b1111 : 4'b0000);
            chk($sformatf("b2b_gnt_c%0d", c), 32'(bus.gnt), c < 8 ? 32'(4'(1) << (c % 4)) : 0);
            chk($sformatf("b2b_start_c%0d", c), 32'(bus.div_start), (c >= 1 && c <= 8) ? 1 : 0);
            if (c >= 1 && c <= 8)
                chk($sformatf("b2b_dvd_c%0d", c), 32'(bus.div_dividend), 6 * ((c - 1) % 4 + 1));
            chk($sformatf("b2b_rsp_c%0d", c), 32'(bus.rsp_valid),
                (c >= 10 && c <= 17) ? 32'(4'(1) << ((c - 10) % 4)) : 0);
            if (c >= 10 && c <= 17)
                chk($sformatf("b2b_q_c%0d", c), 32'(bus.rsp_quotient), 3 * ((c - 10) % 4 + 1));
            if (c != 17)
                chk($sformatf("b2b_busy_c%0d", c), 32'(busy), (c >= 1 && c <= 16) ? 1 : 0);
        end
        chk("b2b_tag_err", 32'(tag_err), 0);

        early = 1'b1;
        set_ops(0, 6'd10, 6'd2);
        for (int c = 0; c < 15; c++) begin
            step(c == 0 ? 4'b0001 : 4'b0000);
            if (c == 0) chk("mis_gnt", 32'(bus.gnt), 32'(4'b0001));
            chk($sformatf("mis_no_rsp_c%0d", c), 32'(bus.rsp_valid), 0);
            if (c == 8) chk("mis_tag_err_pre", 32'(tag_err), 0);
            if (c == 9) chk("mis_tag_err_set", 32'(tag_err), 1);
        end
        early = 1'b0;
        repeat (3) step(4'b0000);
        chk("mis_tag_err_sticky", 32'(tag_err), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
